// File: rtl/id_ex_reg_pkg.sv
// Shared pipeline package: widths, ALU op classes and the ID/EX field bundles.
package id_ex_reg_pkg;

  localparam int XLEN    = 32;
  localparam int REGIDX  = 5;
  localparam int ALUOP_W = 2;

  localparam logic [15:0] BUBBLE_CNT_MAX = 16'hFFFF;

  typedef enum logic [ALUOP_W-1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } aluop_e;

  // Everything in here is forced to zero when a bubble is inserted.
  typedef struct packed {
    logic   pc_to_reg_src;
    logic   branch_ctrl;
    logic   alusrc;
    logic   reg_write;
    logic   rdsrc;
    logic   mem_read;
    logic   mem_write;
    logic   mem_to_reg;
    aluop_e aluop;
    logic   valid;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REGIDX-1:0] rs1_addr;
    logic [REGIDX-1:0] rs2_addr;
    logic [REGIDX-1:0] rd_addr;
    logic [2:0]        funct3;
    logic              funct7b5;
  } dpath_t;

endpackage

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register: async clear, synchronous zero load, hold enable.
module pipe_field_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Zero load wins over hold so a bubble can be inserted during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_q <= '0;
    else if (i_clr)
      r_q <= '0;
    else if (i_en)
      r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall hold, flush-to-bubble and a saturating bubble counter.
module id_ex_reg
  import id_ex_reg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic              PCtoRegSrc_in,
  input  logic              branchCtrl_in,
  input  logic              alusrc_in,
  input  logic              regWrite_in,
  input  logic              rdsrc_in,
  input  logic              memRead_in,
  input  logic              memWrite_in,
  input  logic              memToReg_in,
  input  logic [ALUOP_W-1:0] aluop_in,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [XLEN-1:0]   rs1_data_in,
  input  logic [XLEN-1:0]   rs2_data_in,
  input  logic [XLEN-1:0]   imm_in,
  input  logic [REGIDX-1:0] rs1_addr_in,
  input  logic [REGIDX-1:0] rs2_addr_in,
  input  logic [REGIDX-1:0] rd_addr_in,
  input  logic [2:0]        funct3_in,
  input  logic              funct7b5_in,
  output logic              valid_out,
  output logic              PCtoRegSrc_out,
  output logic              branchCtrl_out,
  output logic              alusrc_out,
  output logic              regWrite_out,
  output logic              rdsrc_out,
  output logic              memRead_out,
  output logic              memWrite_out,
  output logic              memToReg_out,
  output logic [ALUOP_W-1:0] aluop_out,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   rs1_data_out,
  output logic [XLEN-1:0]   rs2_data_out,
  output logic [XLEN-1:0]   imm_out,
  output logic [REGIDX-1:0] rs1_addr_out,
  output logic [REGIDX-1:0] rs2_addr_out,
  output logic [REGIDX-1:0] rd_addr_out,
  output logic [2:0]        funct3_out,
  output logic              funct7b5_out,
  output logic [15:0]       bubble_cnt
);

  ctrl_t       w_ctrl_d;
  ctrl_t       w_ctrl_q;
  dpath_t      w_dp_d;
  dpath_t      w_dp_q;
  logic        w_load;
  logic [15:0] r_bubble_cnt;

  // A flush must still advance the datapath even while stalled.
  assign w_load = ~stall | flush;

  assign w_ctrl_d = '{
    pc_to_reg_src: PCtoRegSrc_in,
    branch_ctrl:   branchCtrl_in,
    alusrc:        alusrc_in,
    reg_write:     regWrite_in,
    rdsrc:         rdsrc_in,
    mem_read:      memRead_in,
    mem_write:     memWrite_in,
    mem_to_reg:    memToReg_in,
    aluop:         aluop_e'(aluop_in),
    valid:         valid_in
  };

  assign w_dp_d = '{
    pc:       pc_in,
    rs1_data: rs1_data_in,
    rs2_data: rs2_data_in,
    imm:      imm_in,
    rs1_addr: rs1_addr_in,
    rs2_addr: rs2_addr_in,
    rd_addr:  rd_addr_in,
    funct3:   funct3_in,
    funct7b5: funct7b5_in
  };

  pipe_field_reg #(.W($bits(ctrl_t))) u_ctrl_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_load),
    .i_clr (flush),
    .i_d   (w_ctrl_d),
    .o_q   (w_ctrl_q)
  );

  pipe_field_reg #(.W($bits(dpath_t))) u_dp_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_load),
    .i_clr (1'b0),
    .i_d   (w_dp_d),
    .o_q   (w_dp_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_bubble_cnt <= '0;
    else if (flush && (r_bubble_cnt != BUBBLE_CNT_MAX))
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
  end

  assign valid_out      = w_ctrl_q.valid;
  assign PCtoRegSrc_out = w_ctrl_q.pc_to_reg_src;
  assign branchCtrl_out = w_ctrl_q.branch_ctrl;
  assign alusrc_out     = w_ctrl_q.alusrc;
  assign regWrite_out   = w_ctrl_q.reg_write;
  assign rdsrc_out      = w_ctrl_q.rdsrc;
  assign memRead_out    = w_ctrl_q.mem_read;
  assign memWrite_out   = w_ctrl_q.mem_write;
  assign memToReg_out   = w_ctrl_q.mem_to_reg;
  assign aluop_out      = w_ctrl_q.aluop;
  assign pc_out         = w_dp_q.pc;
  assign rs1_data_out   = w_dp_q.rs1_data;
  assign rs2_data_out   = w_dp_q.rs2_data;
  assign imm_out        = w_dp_q.imm;
  assign rs1_addr_out   = w_dp_q.rs1_addr;
  assign rs2_addr_out   = w_dp_q.rs2_addr;
  assign rd_addr_out    = w_dp_q.rd_addr;
  assign funct3_out     = w_dp_q.funct3;
  assign funct7b5_out   = w_dp_q.funct7b5;
  assign bubble_cnt     = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed and randomised checks of id_ex_reg against a small behavioural model.
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, valid_in;
  logic        PCtoRegSrc_in, branchCtrl_in, alusrc_in, regWrite_in;
  logic        rdsrc_in, memRead_in, memWrite_in, memToReg_in;
  logic [1:0]  aluop_in;
  logic [31:0] pc_in, rs1_data_in, rs2_data_in, imm_in;
  logic [4:0]  rs1_addr_in, rs2_addr_in, rd_addr_in;
  logic [2:0]  funct3_in;
  logic        funct7b5_in;

  logic        valid_out;
  logic        PCtoRegSrc_out, branchCtrl_out, alusrc_out, regWrite_out;
  logic        rdsrc_out, memRead_out, memWrite_out, memToReg_out;
  logic [1:0]  aluop_out;
  logic [31:0] pc_out, rs1_data_out, rs2_data_out, imm_out;
  logic [4:0]  rs1_addr_out, rs2_addr_out, rd_addr_out;
  logic [2:0]  funct3_out;
  logic        funct7b5_out;
  logic [15:0] bubble_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [10:0]  m_ctrl;
  logic [146:0] m_dp;
  logic [15:0]  m_cnt;
  int           n_flush;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(valid_in),
    .PCtoRegSrc_in(PCtoRegSrc_in), .branchCtrl_in(branchCtrl_in), .alusrc_in(alusrc_in),
    .regWrite_in(regWrite_in), .rdsrc_in(rdsrc_in), .memRead_in(memRead_in),
    .memWrite_in(memWrite_in), .memToReg_in(memToReg_in), .aluop_in(aluop_in),
    .pc_in(pc_in), .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in), .imm_in(imm_in),
    .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in), .rd_addr_in(rd_addr_in),
    .funct3_in(funct3_in), .funct7b5_in(funct7b5_in),
    .valid_out(valid_out), .PCtoRegSrc_out(PCtoRegSrc_out), .branchCtrl_out(branchCtrl_out),
    .alusrc_out(alusrc_out), .regWrite_out(regWrite_out), .rdsrc_out(rdsrc_out),
    .memRead_out(memRead_out), .memWrite_out(memWrite_out), .memToReg_out(memToReg_out),
    .aluop_out(aluop_out), .pc_out(pc_out), .rs1_data_out(rs1_data_out),
    .rs2_data_out(rs2_data_out), .imm_out(imm_out), .rs1_addr_out(rs1_addr_out),
    .rs2_addr_out(rs2_addr_out), .rd_addr_out(rd_addr_out), .funct3_out(funct3_out),
    .funct7b5_out(funct7b5_out), .bubble_cnt(bubble_cnt)
  );

  function automatic logic [10:0] in_ctrl();
    return {PCtoRegSrc_in, branchCtrl_in, alusrc_in, regWrite_in, rdsrc_in,
            memRead_in, memWrite_in, memToReg_in, aluop_in, valid_in};
  endfunction

  function automatic logic [10:0] out_ctrl();
    return {PCtoRegSrc_out, branchCtrl_out, alusrc_out, regWrite_out, rdsrc_out,
            memRead_out, memWrite_out, memToReg_out, aluop_out, valid_out};
  endfunction

  function automatic logic [146:0] in_dp();
    return {pc_in, rs1_data_in, rs2_data_in, imm_in, rs1_addr_in, rs2_addr_in,
            rd_addr_in, funct3_in, funct7b5_in};
  endfunction

  function automatic logic [146:0] out_dp();
    return {pc_out, rs1_data_out, rs2_data_out, imm_out, rs1_addr_out, rs2_addr_out,
            rd_addr_out, funct3_out, funct7b5_out};
  endfunction

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    {PCtoRegSrc_in, branchCtrl_in, alusrc_in, regWrite_in, rdsrc_in} = '0;
    {memRead_in, memWrite_in, memToReg_in, aluop_in, valid_in} = '0;
    {pc_in, rs1_data_in, rs2_data_in, imm_in} = '0;
    {rs1_addr_in, rs2_addr_in, rd_addr_in, funct3_in, funct7b5_in} = '0;
  endtask

  task automatic rand_inputs();
    {PCtoRegSrc_in, branchCtrl_in, alusrc_in, regWrite_in, rdsrc_in} = 5'($urandom);
    {memRead_in, memWrite_in, memToReg_in, aluop_in, valid_in} = 6'($urandom);
    pc_in       = $urandom;
    rs1_data_in = $urandom;
    rs2_data_in = $urandom;
    imm_in      = $urandom;
    {rs1_addr_in, rs2_addr_in, rd_addr_in, funct3_in, funct7b5_in} = 19'($urandom);
  endtask

  // Advance the model with the inputs as they stand, then let the DUT see one edge.
  task automatic step();
    if (flush) begin
      m_ctrl = '0;
      m_dp   = in_dp();
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      n_flush++;
    end else if (!stall) begin
      m_ctrl = in_ctrl();
      m_dp   = in_dp();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_ctrl"}, 192'(out_ctrl()), 192'(m_ctrl));
    chk({tag, "_dp"},   192'(out_dp()),   192'(m_dp));
    chk({tag, "_cnt"},  192'(bubble_cnt), 192'(m_cnt));
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    clear_inputs();
    m_ctrl = '0; m_dp = '0; m_cnt = '0; n_flush = 0;
    #12;
    chk("rst_ctrl", 192'(out_ctrl()), 192'(0));
    chk("rst_dp",   192'(out_dp()),   192'(0));
    chk("rst_cnt",  192'(bubble_cnt), 192'(0));
    rst_n = 1'b1;

    // first instruction after reset
    pc_in = 32'h100; regWrite_in = 1'b1; valid_in = 1'b1;
    step();
    chk("ld_pc",    192'(pc_out),       192'(32'h100));
    chk("ld_rw",    192'(regWrite_out), 192'(1));
    chk("ld_valid", 192'(valid_out),    192'(1));
    chk_model("ld");

    // stall holds
    pc_in = 32'h200;
    step();
    stall = 1'b1; pc_in = 32'h204;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc",  192'(pc_out),     192'(32'h200));
      chk("stall_cnt", 192'(bubble_cnt), 192'(0));
    end

    // flush with stall: flush wins
    flush = 1'b1; memWrite_in = 1'b1; rs2_data_in = 32'hDEADBEEF;
    step();
    chk("fl_memw",  192'(memWrite_out), 192'(0));
    chk("fl_valid", 192'(valid_out),    192'(0));
    chk("fl_rs2",   192'(rs2_data_out), 192'(32'hDEADBEEF));
    chk("fl_pc",    192'(pc_out),       192'(32'h204));
    chk("fl_cnt",   192'(bubble_cnt),   192'(1));

    // invalid slot and rd=x0 pass through untouched
    stall = 1'b0; flush = 1'b0;
    valid_in = 1'b0; regWrite_in = 1'b1; rd_addr_in = 5'd0; memRead_in = 1'b1;
    step();
    chk("inv_valid", 192'(valid_out),    192'(0));
    chk("inv_rw",    192'(regWrite_out), 192'(1));
    chk("inv_rd",    192'(rd_addr_out),  192'(0));
    chk("inv_mr",    192'(memRead_out),  192'(1));
    chk_model("inv");

    // async reset between edges, held across two edges with stall+flush active
    rand_inputs(); valid_in = 1'b1; pc_in = 32'hCAFE0000; flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    chk_model("pre_rst");
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_ctrl", 192'(out_ctrl()), 192'(0));
    chk("arst_dp",   192'(out_dp()),   192'(0));
    chk("arst_cnt",  192'(bubble_cnt), 192'(0));
    stall = 1'b1; flush = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rsth_ctrl", 192'(out_ctrl()), 192'(0));
    chk("rsth_dp",   192'(out_dp()),   192'(0));
    chk("rsth_cnt",  192'(bubble_cnt), 192'(0));
    m_ctrl = '0; m_dp = '0; m_cnt = '0; n_flush = 0;
    #2;
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
    rand_inputs();
    step();
    chk_model("post_rst");

    // randomised stall/flush/valid traffic
    for (int i = 0; i < 10000; i++) begin
      rand_inputs();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 4) == 0);
      step();
      chk_model("rand");
    end
    chk("rand_nflush", 192'(bubble_cnt), 192'((n_flush > 65535) ? 65535 : n_flush));

    // drive the counter to just below saturation, then over it
    flush = 1'b1; stall = 1'b0;
    guard = 0;
    while (m_cnt != 16'hFFFE && guard < 70000) begin
      step();
      guard++;
    end
    chk("fill_cnt", 192'(bubble_cnt), 192'(16'hFFFE));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sat_cnt", 192'(bubble_cnt), 192'(16'hFFFF));
    end
    chk_model("sat");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
